// File: rtl/ball_motion_ctrl.sv
// Avalon-MM ball position/velocity block: advances one packed {x,y} word per frame with cushion bounces.
// Optional macro BALL_MOTION_FRICTION_EN slows each velocity component by 1 every 16th update.
module ball_motion_ctrl #(
    parameter logic [9:0] X_MIN = 10'd16,
    parameter logic [9:0] X_MAX = 10'd623,
    parameter logic [9:0] Y_MIN = 10'd16,
    parameter logic [9:0] Y_MAX = 10'd463
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        frame_tick,
    output logic [19:0] pos_out,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    typedef struct packed {
        logic               hit;
        logic [9:0]         p;
        logic signed [7:0]  v;
    } axis_t;

    state_t state, state_nxt;

    logic [9:0]        pos_x, pos_y;
    logic signed [7:0] vel_x, vel_y;
    logic              run, irq_en, hit;

    axis_t             ax_p1, ay_p1;
    logic signed [7:0] new_vx, new_vy;

    logic wr_en, wr_pos, wr_vel, wr_ctrl, wr_status, cpu_override, commit_en, moving;
    logic unused_wdata;

    function automatic logic signed [7:0] neg_sat(input logic signed [7:0] v);
        if (v == 8'sh80)
            return 8'sh7f;
        return -v;
    endfunction

    // Out-of-range results, including positions already outside the cushions, clamp and reflect.
    function automatic axis_t step_axis(input logic [9:0] p, input logic signed [7:0] v,
                                        input logic [9:0] lo, input logic [9:0] hi);
        axis_t r;
        logic signed [11:0] n;
        n = $signed({2'b00, p}) + $signed({{4{v[7]}}, v});
        r.hit = 1'b0;
        r.p   = n[9:0];
        r.v   = v;
        if (n < $signed({2'b00, lo})) begin
            r.hit = 1'b1;
            r.p   = lo;
            r.v   = neg_sat(v);
        end else if (n > $signed({2'b00, hi})) begin
            r.hit = 1'b1;
            r.p   = hi;
            r.v   = neg_sat(v);
        end
        return r;
    endfunction

    assign wr_en        = chipselect & ~write_n;
    assign wr_pos       = wr_en && (address == 2'd0);
    assign wr_vel       = wr_en && (address == 2'd1);
    assign wr_ctrl      = wr_en && (address == 2'd2);
    assign wr_status    = wr_en && (address == 2'd3);
    assign cpu_override = wr_pos | wr_vel;
    assign commit_en    = (state == COMMIT) && !cpu_override;
    assign moving       = (|vel_x) | (|vel_y);
    assign unused_wdata = ^writedata[31:20];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_tick && run) state_nxt = CALC;
            CALC:    state_nxt = cpu_override ? IDLE : COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // CALC -> COMMIT boundary: registered candidate position/velocity per axis
    always_ff @(posedge clk) begin
        if (state == CALC) begin
            ax_p1 <= step_axis(pos_x, vel_x, X_MIN, X_MAX);
            ay_p1 <= step_axis(pos_y, vel_y, Y_MIN, Y_MAX);
        end
    end

`ifdef BALL_MOTION_FRICTION_EN
    logic [3:0] frame_cnt;

    function automatic logic signed [7:0] toward_zero(input logic signed [7:0] v);
        if (v > 8'sd0)
            return v - 8'sd1;
        if (v < 8'sd0)
            return v + 8'sd1;
        return v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= 4'd0;
        else if (commit_en)
            frame_cnt <= frame_cnt + 4'd1;
    end

    assign new_vx = (frame_cnt == 4'hF) ? toward_zero(ax_p1.v) : ax_p1.v;
    assign new_vy = (frame_cnt == 4'hF) ? toward_zero(ay_p1.v) : ay_p1.v;
`else
    assign new_vx = ax_p1.v;
    assign new_vy = ay_p1.v;
`endif

    // COMMIT -> architectural registers; a CPU write in the same cycle takes priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x  <= 10'd0;
            pos_y  <= 10'd0;
            vel_x  <= 8'sd0;
            vel_y  <= 8'sd0;
            run    <= 1'b0;
            irq_en <= 1'b0;
            hit    <= 1'b0;
        end else begin
            if (wr_pos) begin
                pos_x <= writedata[19:10];
                pos_y <= writedata[9:0];
            end else if (commit_en) begin
                pos_x <= ax_p1.p;
                pos_y <= ay_p1.p;
            end

            if (wr_vel) begin
                vel_x <= $signed(writedata[15:8]);
                vel_y <= $signed(writedata[7:0]);
            end else if (commit_en) begin
                vel_x <= new_vx;
                vel_y <= new_vy;
            end

            if (wr_ctrl) begin
                run    <= writedata[0];
                irq_en <= writedata[1];
            end

            if (commit_en && (ax_p1.hit || ay_p1.hit))
                hit <= 1'b1;
            else if (wr_status && writedata[0])
                hit <= 1'b0;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0: readdata = {12'd0, pos_x, pos_y};
            2'd1: readdata = {16'd0, vel_x, vel_y};
            2'd2: readdata = {30'd0, irq_en, run};
            2'd3: readdata = {30'd0, moving, hit};
            default: readdata = 32'd0;
        endcase
    end

    assign pos_out = {pos_x, pos_y};
    assign busy    = (state != IDLE);
    assign irq     = hit & irq_en;

endmodule
